// File: rtl/simd_pkg.sv
// Shared opcode definitions for the packed-SIMD unit and the decoder special-opcode path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package simd_pkg;

  // Operation code carried from the decoder into the unit.
  typedef logic [2:0] simd_op_t;

  localparam simd_op_t OP_ADD   = 3'b000;  // wrap add
  localparam simd_op_t OP_ADDUS = 3'b001;  // unsigned saturating add
  localparam simd_op_t OP_SUB   = 3'b010;  // wrap subtract
  localparam simd_op_t OP_SUBUS = 3'b011;  // unsigned saturating subtract
  localparam simd_op_t OP_ADDSS = 3'b100;  // signed saturating add
  localparam simd_op_t OP_SUBSS = 3'b101;  // signed saturating subtract
  localparam simd_op_t OP_MINU  = 3'b110;  // unsigned minimum
  localparam simd_op_t OP_MAXU  = 3'b111;  // unsigned maximum

  // True for the ops that can report saturation.
  function automatic logic op_can_sat(input simd_op_t op);
    return (op == OP_ADDUS) || (op == OP_SUBUS) || (op == OP_ADDSS) || (op == OP_SUBSS);
  endfunction

endpackage

// File: rtl/simd_lane.sv
// Single-lane combinational compute block: wrap/saturating add/sub and unsigned min/max.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the enclosing pipeline owns all handshaking.
module simd_lane
  import simd_pkg::*;
#(
  parameter int LANE_W = 8
) (
  input  logic [2:0]        op,
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic              en,
  output logic [LANE_W-1:0] result,
  output logic              sat
);

  localparam logic [LANE_W-1:0] SMAX = {1'b0, {(LANE_W-1){1'b1}}};
  localparam logic [LANE_W-1:0] SMIN = {1'b1, {(LANE_W-1){1'b0}}};

  // One extra bit keeps the carry/borrow out of the lane for the unsigned clamps.
  logic [LANE_W:0] sum_w;
  logic [LANE_W:0] dif_w;
  logic            add_ovf;
  logic            sub_ovf;
  logic            a_lt_b;

  assign sum_w  = {1'b0, a} + {1'b0, b};
  assign dif_w  = {1'b0, a} - {1'b0, b};
  assign a_lt_b = (a < b);

  // Signed overflow: add with like-signed operands, or sub with unlike-signed
  // operands, producing a result whose sign differs from a.
  assign add_ovf = (a[LANE_W-1] == b[LANE_W-1]) && (sum_w[LANE_W-1] != a[LANE_W-1]);
  assign sub_ovf = (a[LANE_W-1] != b[LANE_W-1]) && (dif_w[LANE_W-1] != a[LANE_W-1]);

  // Select the lane result; a disabled lane passes a through and never saturates.
  always_comb begin
    result = a;
    sat    = 1'b0;
    if (en) begin
      case (op)
        OP_ADD:   result = sum_w[LANE_W-1:0];
        OP_ADDUS: begin
          if (sum_w[LANE_W]) begin
            result = '1;
            sat    = 1'b1;
          end else begin
            result = sum_w[LANE_W-1:0];
          end
        end
        OP_SUB:   result = dif_w[LANE_W-1:0];
        OP_SUBUS: begin
          if (dif_w[LANE_W]) begin
            result = '0;
            sat    = 1'b1;
          end else begin
            result = dif_w[LANE_W-1:0];
          end
        end
        OP_ADDSS: begin
          if (add_ovf) begin
            result = a[LANE_W-1] ? SMIN : SMAX;
            sat    = 1'b1;
          end else begin
            result = sum_w[LANE_W-1:0];
          end
        end
        OP_SUBSS: begin
          if (sub_ovf) begin
            result = a[LANE_W-1] ? SMIN : SMAX;
            sat    = 1'b1;
          end else begin
            result = dif_w[LANE_W-1:0];
          end
        end
        OP_MINU:  result = a_lt_b ? a : b;
        OP_MAXU:  result = a_lt_b ? b : a;
      endcase
    end
  end

endmodule

// File: rtl/packed_simd_unit.sv
// Packed-SIMD execution unit: LANES lane-wise ops with per-lane sticky saturation flags.
// Latency: 2 cycles; a beat handshaken in cycle k is presented on out_* in cycle k+2.
// Backpressure: valid/ready; two-beat capacity, combinational ready chain, one beat per cycle.
module packed_simd_unit
  import simd_pkg::*;
#(
  parameter int LANE_W = 8,
  parameter int LANES  = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2:0]                in_op,
  input  logic [LANE_W*LANES-1:0]   in_a,
  input  logic [LANE_W*LANES-1:0]   in_b,
  input  logic [LANES-1:0]          in_mask,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANE_W*LANES-1:0]   out_data,
  output logic [LANES-1:0]          out_sat,
  input  logic                      sat_clr,
  output logic [LANES-1:0]          sat_sticky
);

  localparam int DATA_W = LANE_W * LANES;

  // Operand beat held in the first stage.
  typedef struct packed {
    simd_op_t          op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [LANES-1:0]  mask;
  } s1_t;

  logic              s1_vld;
  s1_t               s1_q;
  logic              s2_adv;
  logic              s2_load;
  logic              in_fire;
  logic [DATA_W-1:0] lane_res;
  logic [LANES-1:0]  lane_sat;

  // S2 frees up when empty or being drained; S1 accepts when empty or moving into S2.
  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_vld || s2_adv;
  assign in_fire  = in_valid && in_ready;
  assign s2_load  = s1_vld && s2_adv;

  // Lane compute blocks, lane 0 in the LSBs; no carries cross lane boundaries.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    simd_lane #(
      .LANE_W (LANE_W)
    ) u_lane (
      .op     (s1_q.op),
      .a      (s1_q.a[g*LANE_W +: LANE_W]),
      .b      (s1_q.b[g*LANE_W +: LANE_W]),
      .en     (s1_q.mask[g]),
      .result (lane_res[g*LANE_W +: LANE_W]),
      .sat    (lane_sat[g])
    );
  end

  // Stage S1: capture operands on input handshake, empty when the beat moves on.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld <= 1'b0;
      s1_q   <= '0;
    end else if (in_fire) begin
      s1_vld    <= 1'b1;
      s1_q.op   <= in_op;
      s1_q.a    <= in_a;
      s1_q.b    <= in_b;
      s1_q.mask <= in_mask;
    end else if (s2_adv) begin
      s1_vld <= 1'b0;
    end
  end

  // Stage S2: register lane results; data and sat hold while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_vld;
      if (s1_vld) begin
        out_data <= lane_res;
        out_sat  <= lane_sat;
      end
    end
  end

  // Sticky flags: set on S2 load, clear on sat_clr; a same-cycle set wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_sticky <= '0;
    end else begin
      sat_sticky <= (sat_clr ? '0 : sat_sticky) | (s2_load ? lane_sat : '0);
    end
  end

endmodule

// File: tb/tb_packed_simd_unit.sv
module tb_packed_simd_unit;
  import simd_pkg::*;

  localparam int LW = 8;
  localparam int LN = 4;
  localparam int DW = LW * LN;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_op = 3'b000;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic [LN-1:0] in_mask = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic [LN-1:0] out_sat;
  logic          sat_clr = 1'b0;
  logic [LN-1:0] sat_sticky;

  int n_checks = 0;
  int n_fail   = 0;

  packed_simd_unit #(.LANE_W(LW), .LANES(LN)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_mask    (in_mask),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sat    (out_sat),
    .sat_clr    (sat_clr),
    .sat_sticky (sat_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: each lane computed from integer arithmetic and clamp rules.
  function automatic void model(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                input logic [LN-1:0] m, output logic [DW-1:0] d, output logic [LN-1:0] s);
    d = '0;
    s = '0;
    for (int i = 0; i < LN; i++) begin
      int ua, ub, sa, sb, r;
      logic st;
      ua = int'(a[i*LW +: LW]);
      ub = int'(b[i*LW +: LW]);
      sa = (ua >= 128) ? ua - 256 : ua;
      sb = (ub >= 128) ? ub - 256 : ub;
      st = 1'b0;
      if (!m[i]) r = ua;
      else begin
        case (op)
          3'd0: r = ua + ub;
          3'd1: begin r = ua + ub; if (r > 255) begin r = 255; st = 1'b1; end end
          3'd2: r = ua - ub + 256;
          3'd3: begin r = ua - ub; if (r < 0) begin r = 0; st = 1'b1; end end
          3'd4: begin
            r = sa + sb;
            if (r > 127) begin r = 127; st = 1'b1; end
            else if (r < -128) begin r = -128; st = 1'b1; end
          end
          3'd5: begin
            r = sa - sb;
            if (r > 127) begin r = 127; st = 1'b1; end
            else if (r < -128) begin r = -128; st = 1'b1; end
          end
          3'd6: r = (ua < ub) ? ua : ub;
          default: r = (ua > ub) ? ua : ub;
        endcase
      end
      d[i*LW +: LW] = r[7:0];
      s[i] = st;
    end
  endfunction

  typedef struct {
    logic [2:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [LN-1:0] m;
    logic [DW-1:0] d;
    logic [LN-1:0] s;
  } vec_t;

  typedef struct {
    logic [DW-1:0] d;
    logic [LN-1:0] s;
  } res_t;

  vec_t vecs[10];
  res_t exp_q[$];

  task automatic drive_beat(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [LN-1:0] m);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_mask  = m;
  endtask

  // One isolated beat: checks acceptance, latency, result and sticky state.
  task automatic apply_vec(input vec_t v);
    @(posedge clk); #1;
    out_ready = 1'b1;
    sat_clr   = 1'b1;
    drive_beat(v.op, v.a, v.b, v.m);
    @(negedge clk);
    chk("vec in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    sat_clr  = 1'b0;
    @(negedge clk);
    chk("vec out_valid one edge after accept", out_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("vec out_valid two edges after accept", out_valid, 1);
    chk("vec out_data", out_data, v.d);
    chk("vec out_sat", out_sat, v.s);
    chk("vec sat_sticky", sat_sticky, v.s);
  endtask

  initial begin
    logic [2:0]    bp_op[3];
    logic [DW-1:0] bp_a[3], bp_b[3], bp_d[3];
    logic [LN-1:0] bp_s[3];
    logic [DW-1:0] md;
    logic [LN-1:0] ms;
    logic [LN-1:0] sticky_acc;
    int idx, nout;
    bit fired;

    vecs[0] = '{3'b001, 32'hF0108001, 32'h201080FF, 4'b1111, 32'hFF20FFFF, 4'b1011};
    vecs[1] = '{3'b101, 32'h807F0500, 32'h01FF0300, 4'b1111, 32'h807F0200, 4'b1100};
    vecs[2] = '{3'b000, 32'h01020304, 32'h10101010, 4'b0101, 32'h01120314, 4'b0000};
    vecs[3] = '{3'b000, 32'h7FFF80FF, 32'h01010101, 4'b1111, 32'h80008100, 4'b0000};
    vecs[4] = '{3'b010, 32'h00100005, 32'h01010006, 4'b1111, 32'hFF0F00FF, 4'b0000};
    vecs[5] = '{3'b011, 32'h05FF1000, 32'h0600100F, 4'b1111, 32'h00FF0000, 4'b1001};
    vecs[6] = '{3'b110, 32'h10FF0080, 32'h20010080, 4'b1111, 32'h10010080, 4'b0000};
    vecs[7] = '{3'b111, 32'h10FF0080, 32'h20010080, 4'b1111, 32'h20FF0080, 4'b0000};
    vecs[8] = '{3'b001, 32'hFFFFFFFF, 32'h01010101, 4'b0000, 32'hFFFFFFFF, 4'b0000};
    vecs[9] = '{3'b100, 32'h7F80407F, 32'h01FF4080, 4'b1111, 32'h7F807FFF, 4'b1110};

    // Reset state
    #12;
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    chk("reset out_sat", out_sat, 0);
    chk("reset sat_sticky", sat_sticky, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post-reset in_ready", in_ready, 1);

    // Directed vector table
    for (int i = 0; i < 10; i++) apply_vec(vecs[i]);

    // Sticky: clear coincident with a saturating S2 load keeps the new flag
    @(posedge clk); #1;
    drive_beat(OP_ADDUS, 32'h000000FF, 32'h00000001, 4'b1111);
    @(posedge clk); #1;
    in_valid = 1'b0;
    sat_clr  = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    @(negedge clk);
    chk("clr+set out_data", out_data, 32'h000000FF);
    chk("clr+set sat_sticky", sat_sticky, 4'b0001);
    @(posedge clk); #1;
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    @(negedge clk);
    chk("clr alone sat_sticky", sat_sticky, 4'b0000);

    // Backpressure: three beats offered into a stalled output
    bp_op[0] = OP_ADD;  bp_a[0] = 32'h01010101; bp_b[0] = 32'h01010101;
    bp_op[1] = OP_SUB;  bp_a[1] = 32'h10203040; bp_b[1] = 32'h01020304;
    bp_op[2] = OP_MAXU; bp_a[2] = 32'h11223344; bp_b[2] = 32'h44332211;
    for (int i = 0; i < 3; i++) model(bp_op[i], bp_a[i], bp_b[i], 4'b1111, bp_d[i], bp_s[i]);
    idx = 0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
      end
      if (idx < 3) drive_beat(bp_op[idx], bp_a[idx], bp_b[idx], 4'b1111);
      else in_valid = 1'b0;
      @(negedge clk);
      if (cyc >= 2) begin
        chk("bp stalled out_valid", out_valid, 1);
        chk("bp stalled out_data", out_data, bp_d[0]);
      end
      if (in_valid && in_ready) idx++;
    end
    chk("bp accepted count", idx, 2);
    chk("bp full in_ready", in_ready, 0);

    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp pop+push in_ready", in_ready, 1);
    nout = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid && out_ready) begin
        if (nout < 3) chk("bp drain out_data", out_data, bp_d[nout]);
        nout++;
      end
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      if (idx < 3) drive_beat(bp_op[idx], bp_a[idx], bp_b[idx], 4'b1111);
      else in_valid = 1'b0;
      @(negedge clk);
    end
    chk("bp drained count", nout, 3);
    chk("bp drained out_valid", out_valid, 0);

    // Reset with both stages full
    @(posedge clk); #1;
    out_ready = 1'b0;
    sat_clr   = 1'b1;
    drive_beat(OP_ADDUS, 32'hFFFFFFFF, 32'h01010101, 4'b1111);
    @(posedge clk); #1;
    sat_clr = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre-reset out_valid", out_valid, 1);
    chk("pre-reset in_ready", in_ready, 0);
    chk("pre-reset sat_sticky", sat_sticky, 4'b1111);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async reset out_valid", out_valid, 0);
    chk("async reset sat_sticky", sat_sticky, 0);
    chk("async reset out_data", out_data, 0);
    @(posedge clk); #3;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("after reset in_ready", in_ready, 1);
      chk("after reset no stale beat", out_valid, 0);
    end

    // Randomized traffic against the reference model
    @(posedge clk); #1;
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    sticky_acc = '0;
    fired = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      if (!in_valid || fired) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_op    = 3'($urandom_range(0, 7));
        in_a     = ($urandom_range(0, 3) == 0) ? 32'h807FFF00 : $urandom;
        in_b     = ($urandom_range(0, 3) == 0) ? 32'h7F8001FF : $urandom;
        in_mask  = ($urandom_range(0, 1) == 0) ? 4'b1111 : 4'($urandom_range(0, 15));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("rand spurious out_valid", out_valid, 0);
        else begin
          res_t r;
          r = exp_q.pop_front();
          chk("rand out_data", out_data, r.d);
          chk("rand out_sat", out_sat, r.s);
          sticky_acc |= r.s;
          chk("rand sticky covers seen sat", sat_sticky & sticky_acc, sticky_acc);
        end
      end
      fired = in_valid && in_ready;
      if (fired) begin
        model(in_op, in_a, in_b, in_mask, md, ms);
        exp_q.push_back('{md, ms});
      end
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid && exp_q.size() != 0) begin
        res_t r;
        r = exp_q.pop_front();
        chk("drain out_data", out_data, r.d);
        chk("drain out_sat", out_sat, r.s);
        sticky_acc |= r.s;
      end
      @(posedge clk); #1;
    end
    chk("rand all results seen", exp_q.size(), 0);
    chk("rand final sat_sticky", sat_sticky, sticky_acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
